// File: rtl/nrisc_ula_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit: FSM states,
// operation codes and flag bit positions.
package nrisc_ula_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int FLAG_OVF  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_DIVZ = 2;

    // Packs the three status bits at their fixed positions.
    function automatic logic [2:0] make_flags(input logic divz, input logic zero, input logic ovf);
        logic [2:0] f;
        f            = 3'b000;
        f[FLAG_DIVZ] = divz;
        f[FLAG_ZERO] = zero;
        f[FLAG_OVF]  = ovf;
        return f;
    endfunction

endpackage

// File: rtl/nrisc_ula_seq_if.sv
// Request/result bundle between a requester (master) and the sequential
// multiply/divide unit (slave).
interface nrisc_ula_seq_if #(parameter int TAM = 16);
    logic           SEQ_start;
    logic           SEQ_op;
    logic [TAM-1:0] SEQ_A;
    logic [TAM-1:0] SEQ_B;
    logic           SEQ_busy;
    logic           SEQ_done;
    logic [TAM-1:0] SEQ_HI;
    logic [TAM-1:0] SEQ_LO;
    logic [2:0]     SEQ_flags;

    modport master (
        output SEQ_start, SEQ_op, SEQ_A, SEQ_B,
        input  SEQ_busy, SEQ_done, SEQ_HI, SEQ_LO, SEQ_flags
    );

    modport slave (
        input  SEQ_start, SEQ_op, SEQ_A, SEQ_B,
        output SEQ_busy, SEQ_done, SEQ_HI, SEQ_LO, SEQ_flags
    );
endinterface

// File: rtl/nrisc_seq_addsub.sv
// Combinational W-bit adder/subtractor shared by the multiply and divide
// iterations; cout is the carry on add and the borrow on subtract.
module nrisc_seq_addsub #(parameter int W = 17) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] res,
    output logic         cout
);
    logic [W:0] full_s;

    // One extra bit captures carry-out or borrow (wrap below zero).
    always_comb begin
        full_s = {(W+1){1'b0}};
        if (sub) begin
            full_s = {1'b0, a} - {1'b0, b};
        end else begin
            full_s = {1'b0, a} + {1'b0, b};
        end
    end

    assign res  = full_s[W-1:0];
    assign cout = full_s[W];
endmodule

// File: rtl/nrisc_ula_seq.sv
// Sequential unsigned multiply (shift-add) and divide (restoring) unit,
// one iteration per clock for TAM clocks, results held until the next DONE.
module nrisc_ula_seq
    import nrisc_ula_seq_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    nrisc_ula_seq_if.slave seq
);
    localparam int             CW       = $clog2(TAM);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TAM-1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic            op_r;
    logic [TAM-1:0]  b_r, hi_r, lo_r;
    logic            busy_r, done_r;
    logic [TAM-1:0]  out_hi_r, out_lo_r;
    logic [2:0]      flags_r;

    logic            accept_s, divz_s, last_s;
    logic [TAM:0]    as_a_s, as_b_s, as_res_s;
    logic            as_sub_s, as_cout_s;
    logic [TAM-1:0]  hi_nx_s, lo_nx_s;
    logic [2:0]      flags_nx_s;

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        divz_s   = 1'b0;
        last_s   = (cnt_r == CNT_LAST);
        case (state_r)
            IDLE: begin
                if (seq.SEQ_start) begin
                    accept_s = 1'b1;
                    if ((seq.SEQ_op == OP_DIV) && (seq.SEQ_B == {TAM{1'b0}})) begin
                        divz_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand selection for the shared adder: HI+B (multiply) or shifted R-B (divide).
    always_comb begin
        as_a_s   = {1'b0, hi_r};
        as_b_s   = {1'b0, (lo_r[0] ? b_r : {TAM{1'b0}})};
        as_sub_s = 1'b0;
        if (op_r == OP_DIV) begin
            as_a_s   = {hi_r, lo_r[TAM-1]};
            as_b_s   = {1'b0, b_r};
            as_sub_s = 1'b1;
        end else begin
            as_sub_s = 1'b0;
        end
    end

    nrisc_seq_addsub #(.W(TAM+1)) u_addsub (
        .a    (as_a_s),
        .b    (as_b_s),
        .sub  (as_sub_s),
        .res  (as_res_s),
        .cout (as_cout_s)
    );

    // Iteration result; the partial remainder always fits TAM bits because it stays below B.
    always_comb begin
        hi_nx_s = as_res_s[TAM:1];
        lo_nx_s = {as_res_s[0], lo_r[TAM-1:1]};
        if (op_r == OP_DIV) begin
            if (as_cout_s) begin
                hi_nx_s = as_a_s[TAM-1:0];
            end else begin
                hi_nx_s = as_res_s[TAM-1:0];
            end
            lo_nx_s    = {lo_r[TAM-2:0], ~as_cout_s};
            flags_nx_s = make_flags(1'b0, (lo_nx_s == {TAM{1'b0}}), 1'b0);
        end else begin
            flags_nx_s = make_flags(1'b0, ({hi_nx_s, lo_nx_s} == {(2*TAM){1'b0}}),
                                    (hi_nx_s != {TAM{1'b0}}));
        end
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            op_r     <= OP_MUL;
            b_r      <= {TAM{1'b0}};
            hi_r     <= {TAM{1'b0}};
            lo_r     <= {TAM{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            out_hi_r <= {TAM{1'b0}};
            out_lo_r <= {TAM{1'b0}};
            flags_r  <= 3'b000;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r   <= seq.SEQ_op;
                        b_r    <= seq.SEQ_B;
                        hi_r   <= {TAM{1'b0}};
                        lo_r   <= seq.SEQ_A;
                        cnt_r  <= {CW{1'b0}};
                        busy_r <= 1'b1;
                        if (divz_s) begin
                            done_r   <= 1'b1;
                            out_hi_r <= seq.SEQ_A;
                            out_lo_r <= {TAM{1'b1}};
                            flags_r  <= make_flags(1'b1, 1'b0, 1'b0);
                        end
                    end
                end
                RUN: begin
                    hi_r  <= hi_nx_s;
                    lo_r  <= lo_nx_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        done_r   <= 1'b1;
                        out_hi_r <= hi_nx_s;
                        out_lo_r <= lo_nx_s;
                        flags_r  <= flags_nx_s;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign seq.SEQ_busy  = busy_r;
    assign seq.SEQ_done  = done_r;
    assign seq.SEQ_HI    = out_hi_r;
    assign seq.SEQ_LO    = out_lo_r;
    assign seq.SEQ_flags = flags_r;
endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Scoreboard bench for nrisc_ula_seq at TAM=16: expected results come from
// native arithmetic and are compared when SEQ_done pulses.
module tb_nrisc_ula_seq;
    localparam int TAM = 16;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [2:0]  fl;
        logic [7:0]  lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    nrisc_ula_seq_if #(.TAM(TAM)) bus ();

    nrisc_ula_seq #(.TAM(TAM)) dut (
        .clk (clk),
        .rst (rst),
        .seq (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation; inj_cyc>0 pulses a stray start, rst_cyc>0 aborts with reset.
    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input int inj_cyc, input int rst_cyc);
        exp_t   e;
        exp_t   got_e;
        logic [31:0] p;
        logic [15:0] last_hi;
        int     cyc;
        bit     got;
        if (op == 1'b0) begin
            p    = 32'(a) * 32'(b);
            e.hi = p[31:16];
            e.lo = p[15:0];
            e.fl = {1'b0, (p == 32'd0), (p[31:16] != 16'd0)};
            e.lat = 8'd17;
        end else if (b == 16'd0) begin
            e.hi = a;
            e.lo = 16'hFFFF;
            e.fl = 3'b100;
            e.lat = 8'd1;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
            e.fl = {1'b0, ((a / b) == 16'd0), 1'b0};
            e.lat = 8'd17;
        end
        if (rst_cyc == 0) sb.push_back(e);

        bus.SEQ_start = 1'b1;
        bus.SEQ_op    = op;
        bus.SEQ_A     = a;
        bus.SEQ_B     = b;
        @(negedge clk);
        bus.SEQ_start = 1'b0;
        bus.SEQ_A     = 16'($urandom);
        bus.SEQ_B     = 16'($urandom);
        cyc = 1;
        got = 1'b0;
        checks++;
        if (bus.SEQ_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b want 1", bus.SEQ_busy);
        end
        while (!got && cyc <= 40) begin
            if (rst_cyc != 0 && cyc == rst_cyc) begin
                rst = 1'b0;
                @(negedge clk);
                checks++;
                if ({bus.SEQ_busy, bus.SEQ_done, bus.SEQ_HI, bus.SEQ_LO, bus.SEQ_flags} !== 37'd0) begin
                    errors++;
                    $display("FAIL abort_outputs: busy=%b done=%b hi=%h lo=%h fl=%b want all 0",
                             bus.SEQ_busy, bus.SEQ_done, bus.SEQ_HI, bus.SEQ_LO, bus.SEQ_flags);
                end
                rst = 1'b1;
                for (int k = 0; k < 24; k++) begin
                    @(negedge clk);
                    if (bus.SEQ_done !== 1'b0 || bus.SEQ_busy !== 1'b0) begin
                        checks++;
                        errors++;
                        $display("FAIL abort_no_done: done=%b busy=%b at idle cycle %0d want 0",
                                 bus.SEQ_done, bus.SEQ_busy, k);
                    end
                end
                return;
            end
            if (inj_cyc != 0 && cyc == inj_cyc) begin
                bus.SEQ_start = 1'b1;
                bus.SEQ_op    = ~op;
                bus.SEQ_A     = 16'h00AA;
                bus.SEQ_B     = 16'h0003;
            end else begin
                bus.SEQ_start = 1'b0;
            end
            if (bus.SEQ_done === 1'b1) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.SEQ_start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: no SEQ_done within 40 cycles (want cycle %0d)", e.lat);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        got_e = sb.pop_front();
        if (cyc !== int'(got_e.lat)) begin
            errors++;
            $display("FAIL latency: got cycle %0d want %0d", cyc, got_e.lat);
        end
        checks++;
        if (bus.SEQ_HI !== got_e.hi || bus.SEQ_LO !== got_e.lo) begin
            errors++;
            $display("FAIL result op=%b a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                     op, a, b, bus.SEQ_HI, bus.SEQ_LO, got_e.hi, got_e.lo);
        end
        checks++;
        if (bus.SEQ_flags !== got_e.fl) begin
            errors++;
            $display("FAIL flags op=%b a=%h b=%h: got %b want %b", op, a, b, bus.SEQ_flags, got_e.fl);
        end
        last_hi = bus.SEQ_HI;
        @(negedge clk);
        checks++;
        if (bus.SEQ_done !== 1'b0 || bus.SEQ_busy !== 1'b0 || bus.SEQ_HI !== last_hi
            || bus.SEQ_flags !== got_e.fl) begin
            errors++;
            $display("FAIL post_done_hold: done=%b busy=%b hi=%h fl=%b want 0 0 %h %b",
                     bus.SEQ_done, bus.SEQ_busy, bus.SEQ_HI, bus.SEQ_flags, last_hi, got_e.fl);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.SEQ_start = 1'b1;
        bus.SEQ_op    = 1'b0;
        bus.SEQ_A     = 16'h0003;
        bus.SEQ_B     = 16'h0005;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.SEQ_busy, bus.SEQ_done, bus.SEQ_HI, bus.SEQ_LO, bus.SEQ_flags} !== 37'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h fl=%b want all 0",
                     bus.SEQ_busy, bus.SEQ_done, bus.SEQ_HI, bus.SEQ_LO, bus.SEQ_flags);
        end
        bus.SEQ_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.SEQ_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_start: busy=%b want 0", bus.SEQ_busy);
        end
    endtask

    task automatic test_mul();
        run_op(1'b0, 16'd3, 16'd5, 0, 0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 0);
        run_op(1'b0, 16'h0000, 16'h1234, 0, 0);
        run_op(1'b0, 16'h8001, 16'h0002, 0, 0);
    endtask

    task automatic test_div();
        run_op(1'b1, 16'd100, 16'd7, 0, 0);
        run_op(1'b1, 16'd0, 16'd9, 0, 0);
        run_op(1'b1, 16'hFFFF, 16'h0001, 0, 0);
        run_op(1'b1, 16'h0005, 16'hFFFF, 0, 0);
        run_op(1'b1, 16'hFFFE, 16'hFFFF, 0, 0);
    endtask

    task automatic test_divz();
        run_op(1'b1, 16'h1234, 16'h0000, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_op(1'b0, 16'h1234, 16'h0056, 5, 0);
    endtask

    task automatic test_reset_abort();
        run_op(1'b0, 16'h0102, 16'h0304, 0, 8);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abort_scoreboard: %0d pending want 0", sb.size());
        end
        run_op(1'b0, 16'd3, 16'd5, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 300)), 0, 0);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.SEQ_start = 1'b0;
        bus.SEQ_op    = 1'b0;
        bus.SEQ_A     = 16'h0000;
        bus.SEQ_B     = 16'h0000;
        @(negedge clk);
        test_reset();
        test_mul();
        test_div();
        test_divz();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nrisc_ula_seq.md
NRISC_ULA_SEQ -- requirements
Module: nrisc_ula_seq

Interface
REQ-001 Parameter: TAM, default 16, operand width in bits; legal values 8..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SEQ_start  input  1  request to start an operation; sampled only in IDLE.
REQ-005 SEQ_op  input  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 SEQ_A  input  TAM  multiplicand or dividend; captured when start is accepted.
REQ-007 SEQ_B  input  TAM  multiplier or divisor; captured when start is accepted.
REQ-008 SEQ_busy  output  1  high from the cycle after acceptance through the DONE cycle.
REQ-009 SEQ_done  output  1  one-cycle pulse; results and flags are valid in that cycle.
REQ-010 SEQ_HI  output  TAM  multiply upper product half, or divide remainder.
REQ-011 SEQ_LO  output  TAM  multiply lower product half, or divide quotient.
REQ-012 SEQ_flags  output  3  {divz, zero, ovf}, registered.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 IDLE with SEQ_start=1 SHALL capture SEQ_A, SEQ_B and SEQ_op, clear the step counter, and go to RUN.
- Exception: if SEQ_op=1 and SEQ_B=0, the FSM SHALL go directly to DONE.
REQ-015 RUN SHALL perform exactly one iteration per cycle for TAM cycles, then go to DONE when counter == TAM-1.
REQ-016 DONE SHALL assert SEQ_done for exactly one cycle, then return to IDLE.
REQ-017 Latency: if start is accepted at cycle 0, SEQ_done SHALL be high at cycle TAM+1; for divide-by-zero, at cycle 1.
REQ-018 SEQ_start SHALL be ignored in RUN and DONE; a new start SHALL be accepted earliest in the cycle after SEQ_done.
REQ-019 Multiply iteration (initial state HI=0, LO=A): form a (TAM+1)-bit sum = HI + (LO[0] ? B : 0), then shift {sum, LO} right by 1 into {HI, LO}.
REQ-020 Divide iteration (initial state R=0, Q=A): shift {R, Q} left by 1, then compute trial = R - B at TAM+1 bits.
- If trial does not borrow: R = trial and Q[0] = 1.
- Otherwise: R is unchanged and Q[0] = 0.
REQ-021 Divide-by-zero SHALL produce Q = all ones, R = A, and divz = 1.
REQ-022 zero SHALL be set when the full result is 0: {HI, LO} for multiply, Q for divide.
REQ-023 ovf SHALL be set for multiply when HI != 0, and SHALL be 0 for divide.
REQ-024 SEQ_HI, SEQ_LO and SEQ_flags SHALL hold their last values until the next DONE cycle.
REQ-025 If SEQ_A or SEQ_B changes during RUN, the in-flight result SHALL be unaffected.

Reset
REQ-026 When rst=0, the FSM SHALL enter IDLE, and SEQ_busy, SEQ_done, SEQ_HI, SEQ_LO, SEQ_flags and the counter SHALL be cleared to 0.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no SEQ_done pulse.
REQ-028 Reset SHALL take priority over SEQ_start in the same cycle.

Structure
REQ-029 A shared package/header SHALL hold:
- the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the SEQ_op constants OP_MUL=1'b0 and OP_DIV=1'b1;
- the flag bit indices.
REQ-030 One sub-module, nrisc_seq_addsub, SHALL implement the (TAM+1)-bit add/subtract with a carry/borrow output.
- It SHALL be shared by both operations.
- It SHALL be purely combinational.
REQ-031 The counter width SHALL be $clog2(TAM) bits.
REQ-032 Target implementation size is 120-400 lines of RTL.

Verification
REQ-033 With TAM=16, MUL 3 x 5, start at cycle 0 -> SEQ_done at cycle 17, HI=0x0000, LO=0x000F, flags=3'b000.
REQ-034 MUL 0xFFFF x 0xFFFF -> HI=0xFFFE, LO=0x0001, ovf=1, zero=0.
REQ-035 DIV 100 / 7 -> LO=14, HI=2, flags=3'b000; DIV 0 / 9 -> LO=0, HI=0, zero=1.
REQ-036 DIV 0x1234 / 0 -> SEQ_done at cycle 1, LO=0xFFFF, HI=0x1234, flags=3'b100.
REQ-037 Start MUL, then pulse SEQ_start with new operands at cycle 5 -> pulse ignored, original result delivered at cycle 17.
REQ-038 Start MUL, drive rst=0 at cycle 8 -> no SEQ_done pulse, all outputs 0, and a new start after reset completes normally.
